mac_result_collector: RTL
=========================

# mac_result_collector

Downstream companion to `mac_cluster`. It tracks every operand set issued to the cluster through the cluster's fixed pipeline latency and captures `out0..out3` in the cycle they become valid. Each capture is tagged with the issue's mode and accumulate bits and buffered in a FIFO drained over a valid/ready port. A credit scheme throttles issue so a captured result is never dropped.

## Interface
Parameters:
- `ACC_WIDTH`, 32: width of one cluster output lane (`MAC_ACC_WIDTH`).
- `LATENCY`, 2: cycles from operand issue to valid `out0..out3`; ≥1.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `issue_valid`  in  1  upstream presents an operand set to the cluster this cycle.
- `issue_ready`  out  1  collector has a credit; issue fires on `issue_valid & issue_ready`.
- `issue_mode`  in  2  cfg mode of this issue: 00 single, 01 dual, 10 quad.
- `issue_acc`  in  1  cfg accumulate bit of this issue.
- `mac_out0..mac_out3`  in  ACC_WIDTH each  cluster outputs `out0..out3`.
- `res_valid`  out  1  FIFO head holds a result.
- `res_ready`  in  1  consumer accepts head; pop on `res_valid & res_ready`.
- `res_data`  out  4*ACC_WIDTH  `{out3,out2,out1,out0}` of head.
- `res_mode`  out  2  mode tag of head.
- `res_acc`  out  1  accumulate tag of head.
- `occupancy`  out  clog2(DEPTH+1)  FIFO entries plus in-flight issues.

## Operation
- Tag pipeline: LATENCY-stage shift register of {valid, mode, acc}; stage 0 loads {fire, issue_mode, issue_acc} each cycle; shifts unconditionally.
- Capture: when last stage valid=1, push {mac_out3..0, mode, acc} into FIFO on that edge.
- Issue `issue_mode` value 11 is accepted and tagged verbatim; no checking.
- FIFO: first-word-fall-through, circular with wrapping read/write pointers; order strictly preserved.
- Credits: `occupancy` = FIFO count + in-flight tags; `issue_ready` = (`occupancy` < DEPTH) & `rst_n`. Depends on registered state only, never on `res_ready` or `issue_valid`.
- `occupancy` update per edge: +1 on fire, −1 on pop, unchanged when both occur. Capture moves an entry from in-flight to FIFO with no net change.
- Push into a full FIFO is unreachable by construction. The bench flags it as an assertion failure.
- Simultaneous push and pop with FIFO count ≥1 leaves count unchanged. With count 0, the pushed entry appears at head after the edge.
- Reset: while `rst_n`=0 at an edge, clear tag pipeline, pointers and count. In-flight and buffered results are discarded, and late cluster outputs for discarded tags are never captured.
- Reset values: `issue_ready`=0 during reset, `res_valid`=0, `occupancy`=0, `res_data`/`res_mode`/`res_acc`=0.

## Timing
- Fire at edge E: tag enters stage 0 at E. `mac_out*` is sampled at edge E+LATENCY, and `res_valid`=1 with data is visible after E+LATENCY.
- Sustained throughput: one issue and one result per cycle when `res_ready`=1 continuously. This needs DEPTH ≥ LATENCY+1; the default DEPTH=4 with LATENCY=2 streams bubble-free.
- Pop at edge P: next entry visible after P; `issue_ready` may rise after P if the credit freed.
- `issue_ready` is 1 in the first cycle after `rst_n` returns high.

## Test plan
- Reset: hold `rst_n`=0 3 cycles with `issue_valid`=1, `res_ready`=1. Required: `issue_ready`=0, `res_valid`=0, `occupancy`=0 throughout; `issue_ready`=1 first cycle after release.
- Single capture: LATENCY=2; fire at edge 0 with mode=00, acc=0; `mac_out0..3`=6,12,20,30 at edge 2. Required: `res_valid`=1 after edge 2, `res_data`={30,20,12,6}, `res_mode`=00. Pop at edge 3 leaves `res_valid`=0 and `occupancy`=0.
- Fill: DEPTH=4, `res_ready`=0, `issue_valid` held 1, `mac_out0` = 1,2,3,4 at capture edges. Required: exactly 4 fires, then `issue_ready`=0 and `occupancy`=4. Assert `res_ready` for one cycle: head 1 popped, head becomes 2, `issue_ready`=1 next cycle.
- Streaming: 10 back-to-back issues with modes cycling 00,01,10 and `res_ready`=1. Required: 10 results in issue order, one per cycle, each exactly LATENCY cycles after its fire, tags matching.
- Concurrent push/pop: FIFO count 2; capture and pop on the same edge. Required: count stays 2, `occupancy` unchanged, order preserved across pointer wrap after ≥DEPTH+1 total entries.
- Reset mid-flight: 2 in FIFO, 2 in tag pipeline; `rst_n`=0 one cycle. Required: `res_valid`=0 and `occupancy`=0 after, with no result emitted for discarded tags despite `mac_out*` toggling.

Source files
------------

// File: rtl/mac_result_collector.sv
// Collects mac_cluster outputs LATENCY cycles after each issue and queues them, tagged, in a FWFT FIFO.
// Issue is credit-throttled against FIFO space plus in-flight tags, so a capture always finds room.
module mac_result_collector #(
  parameter  int ACC_WIDTH = 32,
  parameter  int LATENCY   = 2,
  parameter  int DEPTH     = 4,
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [1:0]             issue_mode,
  input  logic                   issue_acc,
  input  logic [ACC_WIDTH-1:0]   mac_out0,
  input  logic [ACC_WIDTH-1:0]   mac_out1,
  input  logic [ACC_WIDTH-1:0]   mac_out2,
  input  logic [ACC_WIDTH-1:0]   mac_out3,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*ACC_WIDTH-1:0] res_data,
  output logic [1:0]             res_mode,
  output logic                   res_acc,
  output logic [OW-1:0]          occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  typedef struct packed {
    logic       vld;
    logic [1:0] mode;
    logic       acc;
  } tag_t;

  typedef struct packed {
    logic [4*ACC_WIDTH-1:0] data;
    logic [1:0]             mode;
    logic                   acc;
  } ent_t;

  tag_t [LATENCY-1:0] tag_q, tag_d;
  ent_t [DEPTH-1:0]   mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]      cnt_q, cnt_d, occ_q, occ_d;
  logic               fire, push, pop;
  ent_t               head;

  // Credit check uses registered occupancy only; rst_n gates it so nothing fires during reset.
  assign issue_ready = (occ_q < DEPTH_C) & rst_n;
  assign fire        = issue_valid & issue_ready;
  assign push        = tag_q[LATENCY-1].vld;
  assign res_valid   = (cnt_q != '0);
  assign pop         = res_valid & res_ready;
  assign occupancy   = occ_q;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = '{vld: fire, mode: issue_mode, acc: issue_acc};
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: {mac_out3, mac_out2, mac_out1, mac_out0},
                          mode: tag_q[LATENCY-1].mode,
                          acc:  tag_q[LATENCY-1].acc};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // A capture only moves an entry from in-flight to buffered, so occupancy ignores it.
    cnt_d = cnt_q + OW'(push) - OW'(pop);
    occ_d = occ_q + OW'(fire) - OW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the empty count masks stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    res_data = res_valid ? head.data : '0;
    res_mode = res_valid ? head.mode : 2'b00;
    res_acc  = res_valid ? head.acc  : 1'b0;
  end

endmodule
